dense_out_streamer: RTL and testbench

Reader for the dense layer's output bus. When the layer signals completion, the block snapshots the flattened Q1.15 output vector and streams it one word per cycle over a valid/ready handshake. While streaming it tracks the signed argmax, which gives the classifier stage a winning index without a second pass. It sits between the final dense layer and the result sink (UART/host bridge or top-level result register).

---
 rtl/dense_out_streamer_if.sv | 14 +
 rtl/dense_out_streamer.sv | 127 ++++++++++++
 tb/tb_dense_out_streamer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_out_streamer_if.sv
// Valid/ready word stream carrying one signed Q1.15 output word and its index.
// The master drives data/index/valid/last and the slave returns ready.
interface dense_out_streamer_if #(
  parameter int unsigned IW = 8
) ();
  logic [15:0]   data;
  logic [IW-1:0] index;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (output data, index, valid, last, input ready);
  modport slave  (input data, index, valid, last, output ready);
endinterface

// File: rtl/dense_out_streamer.sv
// Snapshots the dense layer's output vector on the rising edge of done and streams it one word per
// handshake, tracking the signed argmax (lowest index wins ties) as the words are accepted.
module dense_out_streamer #(
  parameter int unsigned N  = 100,
  parameter int unsigned IW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [16*N-1:0]      i_y_in,
  input  logic                 i_done,
  dense_out_streamer_if.master out_if,
  output logic                 o_busy,
  output logic [15:0]          o_max_value,
  output logic [IW-1:0]        o_max_index,
  output logic                 o_max_valid
);

  typedef enum logic {StIdle, StStream} state_e;

  state_e        r_state;
  state_e        w_state_d;
  logic          r_done_q;
  logic [15:0]   r_buf [N];
  logic [15:0]   r_out_data;
  logic [IW-1:0] r_idx;
  logic          r_out_last;
  logic [15:0]   r_max_value;
  logic [IW-1:0] r_max_index;
  logic          r_max_valid;

  logic          w_start;
  logic          w_hs;
  logic          w_at_last;
  logic [IW-1:0] w_idx_nxt;
  logic [15:0]   w_word_nxt;

  assign w_start   = i_done && !r_done_q;
  assign w_hs      = (r_state == StStream) && out_if.ready;
  assign w_at_last = (r_idx == IW'(N - 1));
  assign w_idx_nxt = r_idx + 1'b1;

  // Word for the next index, so out_data stays a plain register.
  always_comb begin
    w_word_nxt = '0;
    for (int k = 0; k < N; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_word_nxt = r_buf[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic; starts seen while streaming are dropped.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_start) w_state_d = StStream;
      StStream: if (w_hs && w_at_last) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_if.valid = (r_state == StStream);
    out_if.data  = r_out_data;
    out_if.index = r_idx;
    out_if.last  = r_out_last;
    o_busy       = (r_state == StStream);
    o_max_value  = r_max_value;
    o_max_index  = r_max_index;
    o_max_valid  = r_max_valid;
  end

  // Snapshot buffer is pure datapath and needs no reset.
  always_ff @(posedge clk) begin
    if ((r_state == StIdle) && w_start) begin
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= i_y_in[16*k +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q    <= 1'b0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
      r_max_valid <= 1'b0;
    end else begin
      r_done_q <= i_done;
      if (r_state == StIdle) begin
        if (w_start) begin
          r_idx       <= '0;
          r_out_data  <= i_y_in[15:0];
          r_out_last  <= (N == 1);
          r_max_valid <= 1'b0;
        end
      end else if (w_hs) begin
        // r_out_data always mirrors buf[idx] while streaming.
        if ((r_idx == '0) || ($signed(r_out_data) > $signed(r_max_value))) begin
          r_max_value <= r_out_data;
          r_max_index <= r_idx;
        end
        if (w_at_last) begin
          r_max_valid <= 1'b1;
        end else begin
          r_idx      <= w_idx_nxt;
          r_out_data <= w_word_nxt;
          r_out_last <= (w_idx_nxt == IW'(N - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_dense_out_streamer.sv
// Randomized self-checking bench for dense_out_streamer with an N=4 instance and an N=1 instance.
// Expected words and argmax come from the captured vector via plain integer arithmetic.
module tb_dense_out_streamer;

  localparam int unsigned NA  = 4;
  localparam int unsigned IWA = 3;
  localparam int unsigned NB  = 1;
  localparam int unsigned IWB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a_n, rst_b_n, done_a, done_b;
  logic [16*NA-1:0]  y_a;
  logic [16*NB-1:0]  y_b;
  logic              busy_a, busy_b, mval_a, mval_b;
  logic [15:0]       mv_a, mv_b;
  logic [IWA-1:0]    mi_a;
  logic [IWB-1:0]    mi_b;

  dense_out_streamer_if #(.IW(IWA)) if_a ();
  dense_out_streamer_if #(.IW(IWB)) if_b ();

  dense_out_streamer #(.N(NA), .IW(IWA)) u_dut_a (
    .clk(clk), .rst_n(rst_a_n), .i_y_in(y_a), .i_done(done_a), .out_if(if_a),
    .o_busy(busy_a), .o_max_value(mv_a), .o_max_index(mi_a), .o_max_valid(mval_a)
  );

  dense_out_streamer #(.N(NB), .IW(IWB)) u_dut_b (
    .clk(clk), .rst_n(rst_b_n), .i_y_in(y_b), .i_done(done_b), .out_if(if_b),
    .o_busy(busy_b), .o_max_value(mv_b), .o_max_index(mi_b), .o_max_valid(mval_b)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]    cap [NA];
  logic [15:0]    q_data [$];
  logic [IWA-1:0] q_idx [$];
  logic           q_last [$];

  // Reference argmax: largest signed value, first occurrence wins.
  function automatic void ref_max(output logic [15:0] mv, output logic [IWA-1:0] mi);
    int best;
    best = -40000;
    for (int k = 0; k < NA; k++) if (int'($signed(cap[k])) > best) best = int'($signed(cap[k]));
    mi = '0;
    for (int k = NA - 1; k >= 0; k--) if (int'($signed(cap[k])) == best) mi = IWA'(k);
    mv = 16'(best);
  endfunction

  task automatic start_a();
    @(negedge clk);
    done_a = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NA; k++) y_a[16*k +: 16] = cap[k];
    done_a = 1'b1;
  endtask

  // Sink for DUT a. mode 0: always ready, 1: 1,0,0 repeating, else random.
  // bad counts words that moved while stalled and valid/busy disagreements.
  task automatic collect(input int mode, input int budget, output int cycles, output int bad);
    logic stalled, rdy, pl, fin;
    logic [15:0] pd;
    logic [IWA-1:0] pi;
    q_data.delete(); q_idx.delete(); q_last.delete();
    cycles = 0; bad = 0; stalled = 1'b0; fin = 1'b0; pd = '0; pi = '0; pl = 1'b0;
    while (!fin && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (stalled && (if_a.valid !== 1'b1 || if_a.data !== pd || if_a.index !== pi ||
                      if_a.last !== pl)) bad++;
      if (if_a.valid !== busy_a) bad++;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 3 == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if_a.ready = rdy;
      stalled = if_a.valid && !rdy;
      pd = if_a.data; pi = if_a.index; pl = if_a.last;
      if (if_a.valid && rdy) begin
        q_data.push_back(if_a.data); q_idx.push_back(if_a.index); q_last.push_back(if_a.last);
        fin = if_a.last;
      end
    end
    @(negedge clk);
    if_a.ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({if_a.data, if_a.index, if_a.valid, if_a.last, busy_a, mv_a, mi_a, mval_a} !== '0) begin
      errors++; $display("FAIL reset_a: got %h required 0", {if_a.data, if_a.index, if_a.valid,
                          if_a.last, busy_a, mv_a, mi_a, mval_a});
    end
    checks++;
    if ({if_b.data, if_b.index, if_b.valid, if_b.last, busy_b, mv_b, mi_b, mval_b} !== '0) begin
      errors++; $display("FAIL reset_b: got %h required 0", {if_b.data, if_b.index, if_b.valid,
                          if_b.last, busy_b, mv_b, mi_b, mval_b});
    end
    @(negedge clk);
    rst_a_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, bad;
    logic [15:0] emv;
    logic [IWA-1:0] emi;
    cap[0] = 16'h7FFF; cap[1] = 16'h0000; cap[2] = 16'h8000; cap[3] = 16'h1234;
    start_a();
    collect(0, 20, cyc, bad);
    ref_max(emv, emi);
    checks++;
    if (q_data.size() != NA || cyc != NA || bad != 0) begin
      errors++; $display("FAIL basic_count: words %0d cycles %0d bad %0d required 4 4 0",
                         q_data.size(), cyc, bad);
    end
    for (int k = 0; k < q_data.size() && k < NA; k++) begin
      checks++;
      if (q_data[k] !== cap[k] || q_idx[k] !== IWA'(k) || q_last[k] !== (k == NA - 1)) begin
        errors++; $display("FAIL basic_word%0d: got %h/%0d/%b required %h/%0d/%b", k, q_data[k],
                           q_idx[k], q_last[k], cap[k], k, (k == NA - 1));
      end
    end
    checks++;
    if (mval_a !== 1'b1 || mv_a !== emv || mi_a !== emi || if_a.valid !== 1'b0 ||
        busy_a !== 1'b0) begin
      errors++; $display("FAIL basic_max: got %b %h %0d v%b required 1 %h %0d v0", mval_a, mv_a,
                         mi_a, if_a.valid, emv, emi);
    end
  endtask

  task automatic test_negative();
    int cyc, bad;
    logic [15:0] emv;
    logic [IWA-1:0] emi;
    cap[0] = 16'hFF00; cap[1] = 16'hFFF0; cap[2] = 16'h8000; cap[3] = 16'hFFF0;
    start_a();
    collect(2, 60, cyc, bad);
    ref_max(emv, emi);
    checks++;
    if (q_data.size() != NA || bad != 0) begin
      errors++; $display("FAIL neg_count: words %0d bad %0d required 4 0", q_data.size(), bad);
    end
    checks++;
    if (mval_a !== 1'b1 || mv_a !== emv || mi_a !== emi) begin
      errors++; $display("FAIL neg_max: got %b %h %0d required 1 %h %0d", mval_a, mv_a, mi_a,
                         emv, emi);
    end
  endtask

  task automatic test_backpressure();
    int cyc, bad;
    logic [15:0] emv;
    logic [IWA-1:0] emi;
    for (int k = 0; k < NA; k++) cap[k] = 16'($urandom);
    start_a();
    collect(1, 40, cyc, bad);
    ref_max(emv, emi);
    checks++;
    if (q_data.size() != NA || bad != 0) begin
      errors++; $display("FAIL bp_count: words %0d bad %0d required 4 0", q_data.size(), bad);
    end
    for (int k = 0; k < q_data.size() && k < NA; k++) begin
      checks++;
      if (q_data[k] !== cap[k] || q_idx[k] !== IWA'(k)) begin
        errors++; $display("FAIL bp_word%0d: got %h/%0d required %h/%0d", k, q_data[k], q_idx[k],
                           cap[k], k);
      end
    end
    checks++;
    if (mv_a !== emv || mi_a !== emi) begin
      errors++; $display("FAIL bp_max: got %h %0d required %h %0d", mv_a, mi_a, emv, emi);
    end
  endtask

  task automatic test_done_hold();
    int cyc, bad, extra;
    for (int k = 0; k < NA; k++) cap[k] = 16'($urandom);
    start_a();
    fork
      collect(2, 60, cyc, bad);
      begin
        repeat (2) @(posedge clk);
        #2 y_a = ~y_a;
      end
    join
    for (int k = 0; k < q_data.size() && k < NA; k++) begin
      checks++;
      if (q_data[k] !== cap[k]) begin
        errors++; $display("FAIL snap_word%0d: got %h required %h", k, q_data[k], cap[k]);
      end
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_a.valid !== 1'b0) extra++;
    end
    checks++;
    if (q_data.size() != NA || extra != 0) begin
      errors++; $display("FAIL done_hold: words %0d restarted %0d required 4 0", q_data.size(),
                         extra);
    end
    for (int k = 0; k < NA; k++) cap[k] = 16'($urandom);
    start_a();
    collect(0, 20, cyc, bad);
    checks++;
    if (q_data.size() != NA || q_data[0] !== cap[0] || q_data[NA-1] !== cap[NA-1]) begin
      errors++; $display("FAIL restream: words %0d first %h required 4 %h", q_data.size(),
                         (q_data.size() > 0) ? q_data[0] : 16'h0, cap[0]);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc, bad, n;
    for (int k = 0; k < NA; k++) cap[k] = 16'($urandom);
    start_a();
    n = 0;
    if_a.ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(if_a.valid === 1'b1 && if_a.index === IWA'(2)) && n < 10);
    checks++;
    if (n >= 10 || if_a.last !== 1'b0 || if_a.data !== cap[2]) begin
      errors++; $display("FAIL mid_word2: got %h last %b required %h last 0", if_a.data,
                         if_a.last, cap[2]);
    end
    #2 rst_a_n = 1'b0;
    #1;
    checks++;
    if ({if_a.data, if_a.index, if_a.valid, if_a.last, busy_a, mv_a, mi_a, mval_a} !== '0) begin
      errors++; $display("FAIL mid_reset: got %h required 0", {if_a.data, if_a.index, if_a.valid,
                          if_a.last, busy_a, mv_a, mi_a, mval_a});
    end
    if_a.ready = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    collect(0, 20, cyc, bad);
    checks++;
    if (q_data.size() != NA || q_idx[0] !== '0 || q_data[0] !== cap[0] || cyc != NA) begin
      errors++; $display("FAIL post_reset: words %0d cycles %0d first %h required 4 4 %h",
                         q_data.size(), cyc, (q_data.size() > 0) ? q_data[0] : 16'h0, cap[0]);
    end
  endtask

  task automatic test_random();
    int cyc, bad;
    logic [15:0] emv;
    logic [IWA-1:0] emi;
    logic [15:0] pool [4];
    pool[0] = 16'h8000; pool[1] = 16'h7FFF; pool[2] = 16'hFFFF; pool[3] = 16'h0001;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NA; k++)
        cap[k] = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 3)] : 16'($urandom);
      start_a();
      collect(2, 60, cyc, bad);
      ref_max(emv, emi);
      checks++;
      if (q_data.size() != NA || bad != 0 || mval_a !== 1'b1 || mv_a !== emv || mi_a !== emi)
      begin
        errors++; $display("FAIL rand%0d: words %0d bad %0d max %h %0d required 4 0 %h %0d", it,
                           q_data.size(), bad, mv_a, mi_a, emv, emi);
      end
      for (int k = 0; k < q_data.size() && k < NA; k++) begin
        checks++;
        if (q_data[k] !== cap[k] || q_idx[k] !== IWA'(k)) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h required %h", it, k, q_data[k], cap[k]);
        end
      end
    end
  endtask

  task automatic test_n1();
    logic [15:0] w;
    w = 16'($urandom);
    y_b = w;
    done_b = 1'b1;
    @(negedge clk);
    rst_b_n = 1'b1;
    @(negedge clk);
    checks++;
    if (if_b.valid !== 1'b1 || if_b.last !== 1'b1 || if_b.index !== '0 || if_b.data !== w ||
        mval_b !== 1'b0) begin
      errors++; $display("FAIL n1_word: got v%b l%b %h mv%b required v1 l1 %h mv0", if_b.valid,
                         if_b.last, if_b.data, mval_b, w);
    end
    if_b.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (mval_b !== 1'b1 || mv_b !== w || mi_b !== '0 || if_b.valid !== 1'b0) begin
      errors++; $display("FAIL n1_max: got %b %h %0d v%b required 1 %h 0 v0", mval_b, mv_b, mi_b,
                         if_b.valid, w);
    end
    if_b.ready = 1'b0;
  endtask

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; done_a = 1'b0; done_b = 1'b0;
    y_a = '0; y_b = '0; if_a.ready = 1'b0; if_b.ready = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_done_hold();
    test_reset_midstream();
    test_random();
    test_n1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
